vga_text_renderer: RTL and testbench

Scan-out side of the character display. Generates 640x480@60 VGA timing from the 25 MHz pixel clock. Reads ASCII codes from the read port of the character VRAM (the same {y,x} 13-bit address map the keyboard-side writer uses) and looks each code up in an 8x8 font ROM. Emits a 1-bit pixel with sync signals and a blinking underline cursor.

---
 rtl/vga_text_renderer.sv | 140 ++++++++++++++
 tb/tb_vga_text_renderer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_renderer.sv
// 640x480@60 text-mode scan-out: counters -> char VRAM -> 8x8 font ROM -> 1-bit pixel, sync and blinking cursor.
// Latency 3 cycles from counter value to outputs; free-running, no backpressure.
module vga_text_renderer #(
    parameter int H_VISIBLE    = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_VISIBLE    = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    output logic [12:0] vram_rd_addr,
    input  logic [7:0]  vram_rd_data,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    input  logic [6:0]  cursor_x,
    input  logic [5:0]  cursor_y,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        pixel,
    output logic        frame_start
);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] H_S0   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_S1   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] V_S0   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_S1   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam int BW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    // Per-pixel attributes carried alongside the VRAM/font lookups.
    typedef struct packed {
        logic       vis;
        logic       cur;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [2:0] hx;
    } stage_t;

    logic [9:0]    h_q, h_d, v_q, v_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    stage_t        s1_q, s1_d, s2_q, s2_d;
    logic [2:0]    vy_q, vy_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d;
    logic          video_on_q, video_on_d, pixel_q, pixel_d;
    logic          frame_start_q, frame_start_d;
    logic          visible, glyph_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q           <= '0;
            v_q           <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            s1_q          <= '0;
            s2_q          <= '0;
            vy_q          <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            pixel_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            vy_q          <= vy_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            pixel_q       <= pixel_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Raster counters and frame-rate blink divider; the divider steps on the wrap into (0,0).
    always_comb begin
        h_d           = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
        v_d           = v_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (h_q == H_LAST) begin
            v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
            if (v_q == V_LAST) begin
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d   = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        visible      = (h_q < H_VIS) && (v_q < V_VIS);
        vram_rd_addr = visible ? {v_q[8:3], h_q[9:3]} : 13'd0;
        s1_d         = '0;
        s1_d.vis     = visible;
        s1_d.cur     = blink_phase_q && (h_q[9:3] == cursor_x) && (v_q[8:3] == cursor_y)
                       && (v_q[2:0] == 3'd7);
        s1_d.hs      = (h_q >= H_S0) && (h_q <= H_S1);
        s1_d.vs      = (v_q >= V_S0) && (v_q <= V_S1);
        s1_d.fs      = (h_q == 10'd0) && (v_q == 10'd0);
        s1_d.hx      = h_q[2:0];
        vy_d         = v_q[2:0];
        s2_d         = s1_q;
    end

    assign font_addr = {vram_rd_data, vy_q};

    // Off-screen cells (including an out-of-range cursor) are masked by vis.
    always_comb begin
        glyph_bit     = font_data[3'd7 - s2_q.hx];
        hsync_d       = ~s2_q.hs;
        vsync_d       = ~s2_q.vs;
        video_on_d    = s2_q.vis;
        pixel_d       = s2_q.vis & (glyph_bit | s2_q.cur);
        frame_start_d = s2_q.fs;
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pixel       = pixel_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_text_renderer.sv
// Bench for vga_text_renderer: full-size instance A for line timing/addressing,
// reduced-timing instance B for frame, blink, cursor and mid-frame reset.
module tb_vga_text_renderer;
    typedef struct packed {
        int hv; int hfp; int hsw; int hbp;
        int vv; int vfp; int vsw; int vbp;
        int bf;
    } tim_t;
    typedef struct packed { logic hs; logic vs; logic von; logic pix; logic fs; } out_t;

    localparam tim_t TA = '{640, 16, 96, 48, 480, 10, 2, 33, 30};
    localparam tim_t TB = '{64, 4, 8, 4, 32, 2, 2, 2, 2};
    localparam int FB = 80 * 38;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int pos_a = 0, pos_b = 0;

    logic rst_a = 1'b1, rst_b = 1'b1;
    int mode_a = 1, cx_a = 3, cy_a = 2;
    int mode_b = 2, cx_b = 5, cy_b = 1;
    logic [12:0] vram_rd_addr_a, vram_rd_addr_b;
    logic [7:0]  vram_rd_data_a, vram_rd_data_b, font_data_a, font_data_b;
    logic [10:0] font_addr_a, font_addr_b;
    logic [6:0]  cursor_x_a, cursor_x_b;
    logic [5:0]  cursor_y_a, cursor_y_b;
    logic hsync_a, vsync_a, video_on_a, pixel_a, frame_start_a;
    logic hsync_b, vsync_b, video_on_b, pixel_b, frame_start_b;

    assign cursor_x_a = 7'(cx_a);
    assign cursor_y_a = 6'(cy_a);
    assign cursor_x_b = 7'(cx_b);
    assign cursor_y_b = 6'(cy_b);

    vga_text_renderer dut_a (
        .clk(clk), .rst(rst_a), .vram_rd_addr(vram_rd_addr_a), .vram_rd_data(vram_rd_data_a),
        .font_addr(font_addr_a), .font_data(font_data_a), .cursor_x(cursor_x_a),
        .cursor_y(cursor_y_a), .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a),
        .pixel(pixel_a), .frame_start(frame_start_a));

    vga_text_renderer #(
        .H_VISIBLE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_VISIBLE(32), .V_FP(2), .V_SYNC(2), .V_BP(2), .BLINK_FRAMES(2)
    ) dut_b (
        .clk(clk), .rst(rst_b), .vram_rd_addr(vram_rd_addr_b), .vram_rd_data(vram_rd_data_b),
        .font_addr(font_addr_b), .font_data(font_data_b), .cursor_x(cursor_x_b),
        .cursor_y(cursor_y_b), .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b),
        .pixel(pixel_b), .frame_start(frame_start_b));

    // Character VRAM contents.
    function automatic logic [7:0] vram_fn(input logic [12:0] a);
        if (a == 13'h0282) return 8'h41;
        return a[7:0] ^ {a[12:7], 2'b01};
    endfunction

    // Font ROM contents: 0 = blank, 1 = 0x81 on every row, else an address-derived pattern.
    function automatic logic [7:0] font_fn(input logic [10:0] fa, input int mode);
        if (mode == 0) return 8'h00;
        if (mode == 1) return 8'h81;
        return fa[7:0] ^ {fa[10:8], 5'b10110};
    endfunction

    always @(posedge clk) begin
        vram_rd_data_a <= vram_fn(vram_rd_addr_a);
        vram_rd_data_b <= vram_fn(vram_rd_addr_b);
        font_data_a    <= font_fn(font_addr_a, mode_a);
        font_data_b    <= font_fn(font_addr_b, mode_b);
    end

    function automatic logic [12:0] cell_addr(input int h, input int v, input tim_t t);
        if (h < t.hv && v < t.vv) return {6'(v / 8), 7'(h / 8)};
        return 13'd0;
    endfunction

    // Expected outputs for the raster point that entered the counters 3 cycles ago.
    function automatic out_t model_out(input int pos, input tim_t t, input int cx, input int cy,
                                       input int mode);
        int p, ht, vt, fr, r, h, v;
        logic vis, gbit, cur;
        logic [7:0] gl;
        out_t o;
        o = 5'b11000;
        p = pos - 3;
        if (p < 0) return o;
        ht = t.hv + t.hfp + t.hsw + t.hbp;
        vt = t.vv + t.vfp + t.vsw + t.vbp;
        fr = p / (ht * vt);
        r  = p % (ht * vt);
        h  = r % ht;
        v  = r / ht;
        vis  = (h < t.hv) && (v < t.vv);
        gl   = font_fn({vram_fn(cell_addr(h, v, t)), 3'(v % 8)}, mode);
        gbit = gl[7 - (h % 8)];
        cur  = (h / 8 == cx) && (v / 8 == cy) && (v % 8 == 7) && ((fr / t.bf) % 2 == 1);
        o.hs  = !(h >= t.hv + t.hfp && h < t.hv + t.hfp + t.hsw);
        o.vs  = !(v >= t.vv + t.vfp && v < t.vv + t.vfp + t.vsw);
        o.von = vis;
        o.pix = vis && (gbit || cur);
        o.fs  = (h == 0) && (v == 0);
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            if (mismatched <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string nm, input int pos, input tim_t t, input int cx,
                             input int cy, input int mode, input out_t act,
                             input logic [12:0] addr, input logic [10:0] fa);
        int ht, vt, q, r;
        ht = t.hv + t.hfp + t.hsw + t.hbp;
        vt = t.vv + t.vfp + t.vsw + t.vbp;
        chk({nm, " outputs"}, 32'(act), 32'(model_out(pos, t, cx, cy, mode)));
        r = pos % (ht * vt);
        chk({nm, " vram_rd_addr"}, 32'(addr), 32'(cell_addr(r % ht, r / ht, t)));
        if (pos >= 1) begin
            q = (pos - 1) % (ht * vt);
            chk({nm, " font_addr"}, 32'(fa),
                32'({vram_fn(cell_addr(q % ht, q / ht, t)), 3'((q / ht) % 8)}));
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        bit live_a, live_b;
        live_a = 0;
        live_b = 0;
        forever begin
            @(negedge clk);
            if (rst_a) begin pos_a = 0; live_a = 1; end else pos_a++;
            if (rst_b) begin pos_b = 0; live_b = 1; end else pos_b++;
            if (live_a)
                check_dut("A", pos_a, TA, cx_a, cy_a, mode_a,
                          {hsync_a, vsync_a, video_on_a, pixel_a, frame_start_a},
                          vram_rd_addr_a, font_addr_a);
            if (live_b)
                check_dut("B", pos_b, TB, cx_b, cy_b, mode_b,
                          {hsync_b, vsync_b, video_on_b, pixel_b, frame_start_b},
                          vram_rd_addr_b, font_addr_b);
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic run_a();
        int k, p, hs_low, von_hi, pix_hi, hs_first, fall0, fall1;
        logic prev_hs;
        hs_low = 0; von_hi = 0; pix_hi = 0; hs_first = -1; fall0 = -1; fall1 = -1;
        prev_hs = 1'b1;
        rst_a = 1'b1;
        repeat (5) step();
        chk("A reset outputs", 32'({hsync_a, vsync_a, video_on_a, pixel_a, frame_start_a}),
            32'(5'b11000));
        rst_a = 1'b0;
        for (k = 1; k <= 10; k++) begin
            step();
            if (k == 1) chk("A first addr", 32'(vram_rd_addr_a), 32'(0));
            if (frame_start_a) break;
        end
        chk("A frame_start delay", 32'(k), 32'(3));
        k = 0;
        while (pos_a != 42 * 800 + 17 && k < 40000) begin
            step();
            k++;
            p = pos_a - 3;
            if (p >= 800 && p < 1600) begin
                if (!hsync_a) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = p - 800;
                end
                if (video_on_a) von_hi++;
                if (pixel_a) pix_hi++;
            end
            if (prev_hs && !hsync_a) begin
                if (fall0 < 0) fall0 = p;
                else if (fall1 < 0) fall1 = p;
            end
            prev_hs = hsync_a;
        end
        chk("A addr h17 v42", 32'(vram_rd_addr_a), 32'h0282);
        step();
        chk("A font_addr 0x41 row2", 32'(font_addr_a), 32'h020A);
        chk("A hsync low cycles", 32'(hs_low), 32'(96));
        chk("A hsync start x", 32'(hs_first), 32'(656));
        chk("A video_on cycles", 32'(von_hi), 32'(640));
        chk("A pixel 0x81 count", 32'(pix_hi), 32'(160));
        chk("A line length", 32'(fall1 - fall0), 32'(800));
    endtask

    task automatic reset_b(input int m, input int cx, input int cy);
        rst_b = 1'b1;
        mode_b = m;
        cx_b = cx;
        cy_b = cy;
        repeat (3) step();
        rst_b = 1'b0;
    endtask

    task automatic run_b();
        int p, k, fs_prev, fs_gap, vs_low, total;
        int cnt[5];
        int exp_cnt[5];
        exp_cnt = '{0, 0, 8, 8, 0};
        cnt = '{default: 0};
        reset_b(2, 5, 1);
        repeat (2 * FB + 10) step();

        reset_b(0, 3, 2);
        fs_prev = -1; fs_gap = 0; vs_low = 0;
        for (int i = 0; i < 5 * FB + 2; i++) begin
            step();
            p = pos_b - 3;
            if (p >= 0 && p < 5 * FB && pixel_b) cnt[p / FB]++;
            if (frame_start_b) begin
                if (fs_prev >= 0) fs_gap = p - fs_prev;
                fs_prev = p;
            end
            if (p >= 0 && p < FB && !vsync_b) vs_low++;
        end
        for (int f = 0; f < 5; f++) chk($sformatf("B cursor pixels frame %0d", f),
                                        32'(cnt[f]), 32'(exp_cnt[f]));
        chk("B frame_start spacing", 32'(fs_gap), 32'(FB));
        chk("B vsync low cycles", 32'(vs_low), 32'(160));

        reset_b(0, 3, 2);
        repeat (2 * FB + 20 * 80) step();
        rst_b = 1'b1;
        repeat (2) step();
        rst_b = 1'b0;
        for (k = 1; k <= 10; k++) begin
            step();
            if (frame_start_b) break;
        end
        chk("B restart frame_start delay", 32'(k), 32'(3));
        cnt = '{default: 0};
        for (int i = 0; i < 3 * FB; i++) begin
            step();
            p = pos_b - 3;
            if (p >= 0 && p < 3 * FB && pixel_b) cnt[p / FB]++;
        end
        for (int f = 0; f < 3; f++) chk($sformatf("B restart cursor frame %0d", f),
                                        32'(cnt[f]), 32'(exp_cnt[f]));

        reset_b(0, 9, 1);
        total = 0;
        repeat (4 * FB) begin step(); if (pixel_b) total++; end
        chk("B cursor col out of range", 32'(total), 32'(0));
        reset_b(0, 1, 4);
        total = 0;
        repeat (4 * FB) begin step(); if (pixel_b) total++; end
        chk("B cursor row out of range", 32'(total), 32'(0));
    endtask

    initial begin
        fork
            run_a();
            run_b();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within cycle budget");
        $fatal(1, "watchdog");
    end
endmodule
